// File: rtl/mp_ram_obi_pkg.sv
// Shared constants and the response-pipeline stage type for the multi-port OBI RAM.
package mp_ram_obi_pkg;

  localparam int MAX_PORTS        = 4;
  localparam int MAX_READ_LATENCY = 4;
  localparam int PORT_ID_W        = $clog2(MAX_PORTS);

  // One slot of the response pipeline; data travels in a parallel word pipeline.
  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port_id;
    logic                 err;
    logic                 is_read;
  } rsp_stage_t;

endpackage

// File: rtl/obi_rr_arb.sv
// Round-robin arbiter: one-hot grant from the request vector, searching from
// the port after the last one granted. Grants are suppressed while in reset.
module obi_rr_arb #(
  parameter int  NUM_PORTS = 2,
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PTR_W-1:0]     gnt_idx_o
);

  logic [PTR_W-1:0] last_reg;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Pick the first requester at or after last_reg+1, wrapping around.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PTR_W'((int'(last_reg) + k) % NUM_PORTS);
      if (!found && !rst_i && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        gnt_idx_o    = cand;
      end
    end
  end

  // Pointer moves only when something was granted; reset gives port 0 priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_reg <= PTR_W'(NUM_PORTS - 1);
    end else if (found) begin
      last_reg <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/mp_ram_obi.sv
// Multi-port OBI slave RAM: round-robin shared single-access array with a
// fixed-latency, in-order response pipeline routed back to the granted port.
module mp_ram_obi #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  input  logic [NUM_PORTS-1:0][31:0]            addr_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_PORTS-1:0]                  err_o
);
  import mp_ram_obi_pkg::*;

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int DEPTH  = 2 ** WORD_W;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]      gnt_idx;
  logic                  any_gnt;
  logic [31:0]           sel_addr;
  logic                  sel_we;
  logic [BE_W-1:0]       sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_oor;
  logic [WORD_W-1:0]     word_idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  unused_addr_lsb;

  obi_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx)
  );

  // Steer the winning port's request onto the single array access path.
  assign any_gnt         = |gnt_o;
  assign sel_addr        = addr_i[gnt_idx];
  assign sel_we          = we_i[gnt_idx];
  assign sel_be          = be_i[gnt_idx];
  assign sel_wdata       = wdata_i[gnt_idx];
  assign sel_oor         = |sel_addr[31:ADDR_WIDTH];
  assign word_idx        = sel_addr[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^sel_addr[1:0];
  assign wr_en           = any_gnt && sel_we && !sel_oor;
  assign rd_en           = any_gnt && !sel_we && !sel_oor;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_reg [READ_LATENCY];

  // Byte-masked write, registered read, then delay the read word to match latency.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem[word_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
    if (rd_en) data_reg[0] <= mem[word_idx];
    for (int k = 1; k < READ_LATENCY; k++) data_reg[k] <= data_reg[k-1];
  end

  rsp_stage_t stage_next;
  rsp_stage_t stage_reg [READ_LATENCY];
  rsp_stage_t out_stage;

  // Response descriptor for the transaction accepted this cycle (if any).
  always_comb begin
    stage_next         = '0;
    stage_next.valid   = any_gnt;
    stage_next.port_id = PORT_ID_W'(gnt_idx);
    stage_next.err     = sel_oor;
    stage_next.is_read = !sel_we;
  end

  // Response pipeline; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < READ_LATENCY; k++) stage_reg[k] <= '0;
    end else begin
      stage_reg[0] <= stage_next;
      for (int k = 1; k < READ_LATENCY; k++) stage_reg[k] <= stage_reg[k-1];
    end
  end

  assign out_stage = stage_reg[READ_LATENCY-1];

  // Route the final stage to its port; data is zero unless it is a good read.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_rsp
    logic hit;
    assign hit          = !rst_i && out_stage.valid && (out_stage.port_id == PORT_ID_W'(gi));
    assign rvalid_o[gi] = hit;
    assign err_o[gi]    = hit && out_stage.err;
    assign rdata_o[gi]  = (hit && out_stage.is_read && !out_stage.err) ?
                          data_reg[READ_LATENCY-1] : '0;
  end

endmodule

// File: tb/tb_mp_ram_obi.sv
// Self-checking bench for mp_ram_obi: directed scenarios plus randomized
// traffic, compared each cycle against a transaction-level reference model.
module tb_mp_ram_obi;

  localparam int NP = 2;
  localparam int AW = 14;
  localparam int RL = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        req, gnt, we, rvalid, err;
  logic [NP-1:0][31:0]  addr, wdata, rdata;
  logic [NP-1:0][3:0]   be;

  mp_ram_obi #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: word memory with per-byte knowledge, expected-response queue.
  typedef struct {
    int          port;
    int          due;
    logic [31:0] data;
    bit          data_known;
    bit          err;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] ref_mem[int];
  logic [3:0]  ref_known[int];
  int          last_gnt = NP - 1;
  int          cyc = 0;
  int          win;
  logic [NP-1:0] obs_gnt;

  task automatic accept(int p);
    rsp_t        r;
    logic [31:0] a;
    logic [31:0] word;
    logic [3:0]  kn;
    int          w;
    bit          oor;
    a   = addr[p];
    oor = (a[31:AW] != 0);
    w   = int'(a[AW-1:2]);
    r.port = p; r.due = cyc + RL; r.err = oor; r.data = '0; r.data_known = 1'b1;
    if (we[p]) begin
      if (!oor) begin
        word = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
        kn   = ref_known.exists(w) ? ref_known[w] : 4'h0;
        for (int b = 0; b < 4; b++) begin
          if (be[p][b]) begin
            word[8*b +: 8] = wdata[p][8*b +: 8];
            kn[b] = 1'b1;
          end
        end
        ref_mem[w] = word;
        ref_known[w] = kn;
      end
    end else if (!oor) begin
      r.data       = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
      r.data_known = ref_known.exists(w) && (ref_known[w] == 4'hF);
    end
    last_gnt = p;
    rsp_q.push_back(r);
    $display("txn cyc=%0d port=%0d %s addr=%h be=%b wdata=%h", cyc, p,
             we[p] ? "WR" : "RD", a, be[p], wdata[p]);
  endtask

  // One clock cycle: check outputs against the model, update it, advance.
  task automatic step();
    logic [NP-1:0] exp_gnt;
    rsp_t          cur;
    bit            have;
    bit            mine;
    int            p;
    #1;
    exp_gnt = '0;
    win = -1;
    if (!rst) begin
      for (int k = 1; k <= NP; k++) begin
        p = (last_gnt + k) % NP;
        if (win < 0 && req[p]) win = p;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    obs_gnt = gnt;
    check_eq($sformatf("gnt@%0d", cyc), 32'(gnt), 32'(exp_gnt));
    have = 1'b0;
    if (!rst && rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      cur  = rsp_q.pop_front();
      have = 1'b1;
    end
    for (int q = 0; q < NP; q++) begin
      mine = have && (cur.port == q);
      check_eq($sformatf("rvalid%0d@%0d", q, cyc), 32'(rvalid[q]), 32'(mine));
      check_eq($sformatf("err%0d@%0d", q, cyc), 32'(err[q]), 32'(mine && cur.err));
      if (!mine || cur.data_known)
        check_eq($sformatf("rdata%0d@%0d", q, cyc), rdata[q], mine ? cur.data : 32'h0);
    end
    if (win >= 0) accept(win);
    @(posedge clk);
    if (rst) begin
      rsp_q.delete();
      last_gnt = NP - 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    req = '0; we = '0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic drive(int p, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d;
  endtask

  task automatic op(int p, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    idle();
    drive(p, w, a, b, d);
    step();
  endtask

  task automatic idle_cycles(int n);
    idle();
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  logic [1:0]  rr_exp [4];
  bit          pend [NP];
  bit          pw [NP];
  logic [31:0] pa [NP];
  logic [31:0] pd [NP];
  logic [3:0]  pb [NP];

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    // Reset with both ports requesting: no grants, no responses.
    idle();
    rst = 1'b1;
    req = '1;
    step();
    step();
    rst = 1'b0;

    // Full-word write then read back.
    op(0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
    op(0, 1'b0, 32'h1000, 4'h0, 32'h0);
    idle_cycles(RL + 1);

    // Byte-enable merging.
    op(0, 1'b1, 32'h2000, 4'hF, 32'h0);
    op(0, 1'b1, 32'h2000, 4'b0001, 32'hFFFFFFAA);
    op(0, 1'b1, 32'h2000, 4'b0100, 32'hFFBBFFFF);
    op(0, 1'b0, 32'h2000, 4'h0, 32'h0);
    idle_cycles(RL + 1);

    // Two ports held from reset alternate P0,P1,P0,P1.
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      drive(0, 1'b0, 32'h1000, 4'h0, 32'h0);
      drive(1, 1'b0, 32'h2000, 4'h0, 32'h0);
      step();
      check_eq($sformatf("rr_seq%0d", k), 32'(obs_gnt), 32'(rr_exp[k]));
    end
    idle_cycles(RL + 1);

    // Back-to-back writes with no wait states, then read back.
    op(0, 1'b1, 32'h3000, 4'hF, 32'h11111111);
    op(0, 1'b1, 32'h3004, 4'hF, 32'h22222222);
    op(0, 1'b1, 32'h3008, 4'hF, 32'h33333333);
    op(0, 1'b0, 32'h3000, 4'h0, 32'h0);
    op(0, 1'b0, 32'h3005, 4'h0, 32'h0);
    op(0, 1'b0, 32'h300B, 4'h0, 32'h0);
    idle_cycles(RL + 1);

    // Out-of-range write must not alias onto word 0.
    op(1, 1'b1, 32'h0000_0000, 4'hF, 32'h12345678);
    op(1, 1'b1, 32'h0001_0000, 4'hF, 32'hCAFEF00D);
    op(1, 1'b0, 32'h0000_0000, 4'h0, 32'h0);
    op(1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
    idle_cycles(RL + 1);

    // Reset one cycle after a read grant drops its response; P0 wins afterwards.
    op(0, 1'b0, 32'h1000, 4'h0, 32'h0);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(RL + 1);
    idle();
    drive(0, 1'b0, 32'h3000, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h3004, 4'h0, 32'h0);
    step();
    check_eq("post_rst_gnt", 32'(obs_gnt), 32'h1);
    idle_cycles(RL + 1);

    // Randomized two-port traffic over a small window; requests held until granted.
    for (int k = 0; k < 8; k++) op(k % NP, 1'b1, 32'h400 + 32'(4 * k), 4'hF, $urandom);
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      idle();
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1'b1;
          pw[p]   = ($urandom_range(0, 1) == 1);
          pa[p]   = 32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
          if ($urandom_range(0, 9) == 0) pa[p] = pa[p] | (32'h1 << $urandom_range(AW, 31));
          pb[p]   = 4'($urandom_range(0, 15));
          pd[p]   = $urandom;
        end
        if (pend[p]) drive(p, pw[p], pa[p], pb[p], pd[p]);
      end
      step();
      if (win >= 0) pend[win] = 1'b0;
    end
    idle_cycles(RL + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_ram_obi.md
MP_RAM_OBI -- requirements
Module: mp_ram_obi

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of OBI slave ports (1..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, byte-address width of the array (depth = 2^(ADDR_WIDTH-2) words).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width (fixed 32; be width = DATA_WIDTH/8).
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from grant to rvalid (1..4).
REQ-005 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_i  input  [NUM_PORTS]  per-port OBI request.
REQ-008 SHALL have port gnt_o  output  [NUM_PORTS]  per-port grant, combinational from req_i and arbiter state.
REQ-009 SHALL have port addr_i  input  [NUM_PORTS][32]  per-port byte address.
REQ-010 SHALL have port we_i  input  [NUM_PORTS]  per-port write enable.
REQ-011 SHALL have port be_i  input  [NUM_PORTS][4]  per-port byte enables.
REQ-012 SHALL have port wdata_i  input  [NUM_PORTS][32]  per-port write data.
REQ-013 SHALL have port rvalid_o  output  [NUM_PORTS]  per-port response valid.
REQ-014 SHALL have port rdata_o  output  [NUM_PORTS][32]  per-port read data.
REQ-015 SHALL have port err_o  output  [NUM_PORTS]  per-port error, valid with rvalid_o.

Function
REQ-016 SHALL perform at most one array access per cycle; at most one gnt_o bit high per cycle.
REQ-017 SHALL arbitrate round-robin: search starts at port (last_granted+1) mod NUM_PORTS; pointer updates only on a cycle with a grant.
REQ-018 SHALL grant in the same cycle as req when port wins; transaction accepted when req_i & gnt_o.
REQ-019 SHALL sustain back-to-back grants (one per cycle) to a single requesting port with no wait states.
REQ-020 SHALL index the array with addr_i[ADDR_WIDTH-1:2]; addr_i[1:0] ignored.
REQ-021 SHALL write only bytes with be_i[n]=1; other bytes unchanged.
REQ-022 SHALL flag out-of-range when addr_i[31:ADDR_WIDTH] != 0: no array write, err_o=1, rdata_o=0.
REQ-023 SHALL return exactly one response per accepted transaction (reads and writes) on the granting port, exactly READ_LATENCY cycles after acceptance, in acceptance order.
REQ-024 SHALL drive rdata_o=0 for write responses and whenever rvalid_o=0.
REQ-025 SHALL return, for a read accepted the cycle after a write to the same word, the newly written data.
REQ-026 SHALL carry the response pipeline as READ_LATENCY stages of {valid, port_id, err, is_read}; no backpressure (OBI requires no rready).
REQ-027 SHALL treat unrequested ports as gnt_o=0, rvalid_o=0 except for pending responses.

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, clear gnt_o-affecting state: round-robin pointer to NUM_PORTS-1 (port 0 first priority).
REQ-029 SHALL hold rvalid_o=0, err_o=0, rdata_o=0 during reset and discard all in-flight responses (reset mid-operation drops them).
REQ-030 SHALL drive gnt_o=0 while rst_i=1; array contents not reset.

Structure
REQ-031 SHALL place MAX_PORTS=4, MAX_READ_LATENCY=4 and the response-stage struct typedef in package mp_ram_obi_pkg.
REQ-032 SHALL implement arbitration in sub-module obi_rr_arb (req vector in, one-hot grant out, pointer register inside).

Verification
REQ-033 SHALL cover: P0 write 0x1000=0xDEADBEEF be=1111, then P0 read 0x1000 -> rvalid READ_LATENCY cycles later, rdata=0xDEADBEEF, err=0.
REQ-034 SHALL cover: write 0x2000=0, be=0001 data 0xFFFFFFAA, be=0100 data 0xFFBBFFFF, read -> 0x00BB00AA.
REQ-035 SHALL cover: P0 and P1 req held 4 cycles from reset -> grants P0,P1,P0,P1; responses routed to matching port.
REQ-036 SHALL cover: P0 back-to-back writes 0x3000/4/8 = 0x11111111/0x22222222/0x33333333 -> gnt every cycle, three write rvalids, reads return values.
REQ-037 SHALL cover: P1 write 0x0001_0000 -> err_o=1, rdata=0; read of 0x0000 unchanged.
REQ-038 SHALL cover: rst_i asserted one cycle after read grant with READ_LATENCY=3 -> no rvalid emitted; first post-reset grant to P0.
